// File: rtl/xge_wb_cfg_sequencer.sv
// rtl/xge_wb_cfg_sequencer.sv - table-driven wishbone master that writes, reads and polls the 10GE MAC register file
module xge_wb_cfg_sequencer #(
    parameter int NUM_ENTRIES    = 8,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int POLL_LIMIT     = 16
) (
    input  logic                           wb_clk_i,
    input  logic                           wb_rst_i,
    input  logic                           prog_we,
    input  logic [$clog2(NUM_ENTRIES)-1:0] prog_idx,
    input  logic [1:0]                     prog_op,
    input  logic [7:0]                     prog_adr,
    input  logic [31:0]                    prog_dat,
    input  logic [31:0]                    prog_mask,
    input  logic                           start,
    output logic                           busy,
    output logic                           done,
    output logic                           error,
    output logic [$clog2(NUM_ENTRIES)-1:0] err_idx,
    output logic [1:0]                     err_code,
    output logic [31:0]                    rd_data,
    output logic [7:0]                     wb_adr_o,
    output logic [31:0]                    wb_dat_o,
    output logic                           wb_we_o,
    output logic                           wb_cyc_o,
    output logic                           wb_stb_o,
    input  logic [31:0]                    wb_dat_i,
    input  logic                           wb_ack_i
);

    localparam int IW = $clog2(NUM_ENTRIES);

    localparam logic [1:0] OP_END   = 2'd0;
    localparam logic [1:0] OP_WRITE = 2'd1;
    localparam logic [1:0] OP_POLL  = 2'd3;

    localparam logic [1:0] CODE_TIMEOUT = 2'd1;
    localparam logic [1:0] CODE_POLL    = 2'd2;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        BUS,
        DONE_ST,
        ERR_ST
    } state_t;

    logic [1:0]  r_tbl_op   [NUM_ENTRIES];
    logic [7:0]  r_tbl_adr  [NUM_ENTRIES];
    logic [31:0] r_tbl_dat  [NUM_ENTRIES];
    logic [31:0] r_tbl_mask [NUM_ENTRIES];

    state_t      r_state;
    logic [IW-1:0] r_idx;
    logic [1:0]  r_op;
    logic [31:0] r_cmp_dat;
    logic [31:0] r_cmp_mask;
    logic [7:0]  r_poll_cnt;
    logic [15:0] r_wait;
    logic        r_busy;
    logic        r_done;
    logic        r_error;
    logic [IW-1:0] r_err_idx;
    logic [1:0]  r_err_code;
    logic [31:0] r_rd_data;
    logic [7:0]  r_adr;
    logic [31:0] r_dat;
    logic        r_we;
    logic        r_cyc;
    logic        r_stb;

    logic        w_last;
    logic        w_poll_miss;
    logic        w_poll_exhausted;
    logic        w_timeout;

    assign w_last           = (r_idx == IW'(NUM_ENTRIES - 1));
    assign w_poll_miss      = (r_op == OP_POLL) && ((wb_dat_i & r_cmp_mask) != (r_cmp_dat & r_cmp_mask));
    assign w_poll_exhausted = (r_poll_cnt == 8'(POLL_LIMIT - 1));
    assign w_timeout        = (r_wait == 16'(TIMEOUT_CYCLES - 1));

    // Table writes are refused for the whole run so a sequence cannot be edited under itself.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                r_tbl_op[i]   <= OP_END;
                r_tbl_adr[i]  <= 8'h00;
                r_tbl_dat[i]  <= 32'h0;
                r_tbl_mask[i] <= 32'h0;
            end
        end else if (prog_we && !r_busy) begin
            r_tbl_op[prog_idx]   <= prog_op;
            r_tbl_adr[prog_idx]  <= prog_adr;
            r_tbl_dat[prog_idx]  <= prog_dat;
            r_tbl_mask[prog_idx] <= prog_mask;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state    <= IDLE;
            r_idx      <= '0;
            r_op       <= OP_END;
            r_cmp_dat  <= 32'h0;
            r_cmp_mask <= 32'h0;
            r_poll_cnt <= 8'h0;
            r_wait     <= 16'h0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_err_idx  <= '0;
            r_err_code <= 2'd0;
            r_rd_data  <= 32'h0;
            r_adr      <= 8'h00;
            r_dat      <= 32'h0;
            r_we       <= 1'b0;
            r_cyc      <= 1'b0;
            r_stb      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state    <= LOAD;
                        r_busy     <= 1'b1;
                        r_idx      <= '0;
                        r_error    <= 1'b0;
                        r_err_code <= 2'd0;
                        r_err_idx  <= '0;
                        r_poll_cnt <= 8'h0;
                        r_wait     <= 16'h0;
                    end
                end
                LOAD: begin
                    if (r_tbl_op[r_idx] == OP_END) begin
                        r_state <= DONE_ST;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_op       <= r_tbl_op[r_idx];
                        r_adr      <= r_tbl_adr[r_idx];
                        r_we       <= (r_tbl_op[r_idx] == OP_WRITE);
                        r_dat      <= (r_tbl_op[r_idx] == OP_WRITE) ? r_tbl_dat[r_idx] : 32'h0;
                        r_cmp_dat  <= r_tbl_dat[r_idx];
                        r_cmp_mask <= r_tbl_mask[r_idx];
                        r_cyc      <= 1'b1;
                        r_stb      <= 1'b1;
                        r_state    <= BUS;
                    end
                end
                BUS: begin
                    if (wb_ack_i) begin
                        r_cyc  <= 1'b0;
                        r_stb  <= 1'b0;
                        r_wait <= 16'h0;
                        if (r_op != OP_WRITE) begin
                            r_rd_data <= wb_dat_i;
                        end
                        if (w_poll_miss) begin
                            if (w_poll_exhausted) begin
                                r_state    <= ERR_ST;
                                r_error    <= 1'b1;
                                r_err_code <= CODE_POLL;
                                r_err_idx  <= r_idx;
                                r_busy     <= 1'b0;
                            end else begin
                                r_poll_cnt <= r_poll_cnt + 8'd1;
                                r_state    <= LOAD;
                            end
                        end else begin
                            r_poll_cnt <= 8'h0;
                            if (w_last) begin
                                r_state <= DONE_ST;
                                r_done  <= 1'b1;
                                r_busy  <= 1'b0;
                            end else begin
                                r_idx   <= r_idx + IW'(1);
                                r_state <= LOAD;
                            end
                        end
                    end else if (w_timeout) begin
                        r_cyc      <= 1'b0;
                        r_stb      <= 1'b0;
                        r_wait     <= 16'h0;
                        r_state    <= ERR_ST;
                        r_error    <= 1'b1;
                        r_err_code <= CODE_TIMEOUT;
                        r_err_idx  <= r_idx;
                        r_busy     <= 1'b0;
                    end else begin
                        r_wait <= r_wait + 16'd1;
                    end
                end
                // Terminal states last one cycle so a coincident start is only seen from IDLE.
                DONE_ST: r_state <= IDLE;
                ERR_ST:  r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign error    = r_error;
    assign err_idx  = r_err_idx;
    assign err_code = r_err_code;
    assign rd_data  = r_rd_data;
    assign wb_adr_o = r_adr;
    assign wb_dat_o = r_dat;
    assign wb_we_o  = r_we;
    assign wb_cyc_o = r_cyc;
    assign wb_stb_o = r_stb;

endmodule
